// File: rtl/coords_ram_pkg.sv
// Shared constants, FSM state type and status-word helpers for the coordinate RAM responder.
package coords_ram_pkg;

  localparam int unsigned COORDS_ADDR_W = 5;
  localparam int unsigned COORDS_DATA_W = 32;
  localparam logic [COORDS_ADDR_W-1:0] COORDS_STATUS_ADDR = 5'd31;
  localparam int unsigned COORDS_SLOTS = 31;

  // Status word: {frame_count[15:0], drop_flag, 10'b0, valid_count[4:0]}
  localparam int unsigned STATUS_COUNT_LSB = 0;
  localparam int unsigned STATUS_COUNT_W   = 5;
  localparam int unsigned STATUS_DROP_BIT  = 15;
  localparam int unsigned STATUS_FRAME_LSB = 16;
  localparam int unsigned STATUS_FRAME_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SWAP = 2'd2
  } state_t;

  function automatic logic [STATUS_COUNT_W-1:0] popcount_slots(input logic [COORDS_SLOTS-1:0] mask);
    logic [STATUS_COUNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < COORDS_SLOTS; i++) cnt = cnt + {4'b0, mask[i]};
    return cnt;
  endfunction

  function automatic logic [COORDS_DATA_W-1:0] build_status(
    input logic [STATUS_FRAME_W-1:0] frame_count,
    input logic                      drop_flag,
    input logic [STATUS_COUNT_W-1:0] valid_count
  );
    logic [COORDS_DATA_W-1:0] s;
    s = '0;
    s[STATUS_FRAME_LSB +: STATUS_FRAME_W] = frame_count;
    s[STATUS_DROP_BIT]                     = drop_flag;
    s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = valid_count;
    return s;
  endfunction

endpackage

// File: rtl/coords_cmd_capture.sv
// Turns Nios coords-RAM write-port changes into one-cycle command pulses.
module coords_cmd_capture
  import coords_ram_pkg::*;
#(
  parameter int ADDR_W = COORDS_ADDR_W,
  parameter int DATA_W = COORDS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data
);

  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  logic              changed;

  assign changed = (write_addr != last_addr) || (write_data != last_data);

  // The captured values double as the command payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      last_data <= '0;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= changed;
      if (changed) begin
        last_addr <= write_addr;
        last_data <= write_data;
      end
    end
  end

  assign cmd_addr = last_addr;
  assign cmd_data = last_data;

endmodule

// File: rtl/coords_ram_responder.sv
// Double-buffered coordinate table with a status word, read by the Nios over its coords-RAM port.
// Optional command capture of Nios writes is built when COORDS_RAM_CMD_EN is defined.
module coords_ram_responder
  import coords_ram_pkg::*;
#(
  parameter int ADDR_W = COORDS_ADDR_W,
  parameter int DATA_W = COORDS_DATA_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] coords_ram_read_addr,
  output logic [DATA_W-1:0] coords_ram_read_data,
  input  logic [ADDR_W-1:0] coords_ram_write_addr,
  input  logic [DATA_W-1:0] coords_ram_write_data,
  input  logic              frame_start,
  input  logic              frame_done,
  input  logic              coord_valid,
  output logic              coord_ready,
  input  logic [ADDR_W-1:0] coord_idx,
  input  logic [DATA_W-1:0] coord_data,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data
);

  state_t state, state_next;

  logic                    bank_sel;
  logic [DATA_W-1:0]       bank_mem  [2][COORDS_SLOTS];
  logic [COORDS_SLOTS-1:0] bank_mask [2];
  logic [COORDS_SLOTS-1:0] back_mask_next;
  logic                    back;
  logic                    fill_drop;
  logic                    front_drop;
  logic [15:0]             frame_count;
  logic                    ready_p1;

  logic clear_back, accept, slot_write, do_swap;

  logic                    pub_sel;
  logic                    pub_drop;
  logic [15:0]             pub_count;
  logic [COORDS_SLOTS-1:0] pub_mask;
  logic [DATA_W-1:0]       status_word;
  logic [DATA_W-1:0]       read_data_p1;

  assign back = ~bank_sel;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = FILL;
      FILL:    if (!frame_start && frame_done) state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A restart clears the back bank before any same-cycle beat is applied.
  always_comb begin
    clear_back = 1'b0;
    accept     = 1'b0;
    do_swap    = 1'b0;
    case (state)
      IDLE: clear_back = frame_start;
      FILL: begin
        clear_back = frame_start;
        accept     = coord_valid && ready_p1;
      end
      SWAP:    do_swap = 1'b1;
      default: ;
    endcase
  end

  assign slot_write = accept && (coord_idx != COORDS_STATUS_ADDR);

  always_comb begin
    back_mask_next = clear_back ? '0 : bank_mask[back];
    if (slot_write) back_mask_next[coord_idx] = 1'b1;
  end

  always_ff @(posedge clk_clk) begin
    if (slot_write) bank_mem[back][coord_idx] <= coord_data;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bank_mask[0] <= '0;
      bank_mask[1] <= '0;
      bank_sel     <= 1'b0;
      fill_drop    <= 1'b0;
      front_drop   <= 1'b0;
      frame_count  <= '0;
      ready_p1     <= 1'b0;
    end else begin
      bank_mask[back] <= back_mask_next;
      ready_p1        <= (state_next == FILL);
      if (clear_back)                                          fill_drop <= 1'b0;
      else if (accept && (coord_idx == COORDS_STATUS_ADDR))    fill_drop <= 1'b1;
      if (do_swap) begin
        bank_sel    <= ~bank_sel;
        frame_count <= frame_count + 16'd1;
        front_drop  <= fill_drop;
      end
    end
  end

  assign coord_ready = ready_p1;

  // During SWAP the read path already presents the bank being published.
  assign pub_sel     = bank_sel ^ do_swap;
  assign pub_count   = do_swap ? frame_count + 16'd1 : frame_count;
  assign pub_drop    = do_swap ? fill_drop : front_drop;
  assign pub_mask    = bank_mask[pub_sel];
  assign status_word = build_status(pub_count, pub_drop, popcount_slots(pub_mask));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      read_data_p1 <= '0;
    end else if (coords_ram_read_addr == COORDS_STATUS_ADDR) begin
      read_data_p1 <= status_word;
    end else if (pub_mask[coords_ram_read_addr]) begin
      read_data_p1 <= bank_mem[pub_sel][coords_ram_read_addr];
    end else begin
      read_data_p1 <= '0;
    end
  end

  assign coords_ram_read_data = read_data_p1;

`ifdef COORDS_RAM_CMD_EN
  coords_cmd_capture #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmd_capture (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .write_addr(coords_ram_write_addr),
    .write_data(coords_ram_write_data),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data)
  );
`else
  logic unused_write;
  assign unused_write = ^{coords_ram_write_addr, coords_ram_write_data};
  assign cmd_valid    = 1'b0;
  assign cmd_addr     = '0;
  assign cmd_data     = '0;
`endif

endmodule
